// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (serial_adder, serial_subtractor):
// the three-state sequencing enum and the operand-counter width helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } arith_state_e;

    // Counter must hold 0..N, so it needs enough bits for N+1 distinct values.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = x - y - bin, with borrow-out.
module serial_full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: captures a/b on a load in IDLE, computes a - b LSB-first one bit
// per clock, then holds diff/bout with done. Optional macro SERIAL_SUB_OVF_EN adds a signed ovf output.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         busy,
    output logic         done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = count_width(N);

    arith_state_e  state_q;
    logic [N-1:0]  ra_q;
    logic [N-1:0]  rb_q;
    logic [N-1:0]  result_q;
    logic [N-1:0]  result_d;
    logic [N:0]    result_shift;
    logic          borrow_q;
    logic [CW-1:0] count_q;
    logic          bout_q;
    logic          busy_q;
    logic          done_q;
    logic          cell_d;
    logic          cell_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic          a_msb_q;
    logic          b_msb_q;
    logic          ovf_q;
`endif

    serial_full_subtractor u_cell (
        .x    (ra_q[0]),
        .y    (rb_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // New bit enters at the MSB; the widened shift keeps this legal for N == 1.
    assign result_shift = {cell_d, result_q} >> 1;
    assign result_d     = result_shift[N-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            result_q <= '0;
            borrow_q <= 1'b0;
            count_q  <= '0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        ra_q     <= a;
                        rb_q     <= b;
                        borrow_q <= 1'b0;
                        count_q  <= '0;
                        result_q <= '0;
                        busy_q   <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q  <= a[N-1];
                        b_msb_q  <= b[N-1];
`endif
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    result_q <= result_d;
                    borrow_q <= cell_bout;
                    ra_q     <= ra_q >> 1;
                    rb_q     <= rb_q >> 1;
                    count_q  <= count_q + CW'(1);
                    if (count_q == CW'(N - 1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bout_q  <= cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                        // cell_d is the final difference MSB on this edge.
                        ovf_q   <= (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // A load still held from the start edge must drop before another run.
                    if (!load) begin
                        done_q  <= 1'b0;
                        bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q   <= 1'b0;
`endif
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    bout_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign diff = result_q;
    assign bout = bout_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors, load-hold, mid-run reset,
// operand toggling and random operations checked against plain modular arithmetic.
module tb_serial_subtractor;

    localparam int N = 4;
    localparam logic [N-1:0] MASK = '1;
`ifdef SERIAL_SUB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         load;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] diff;
    logic         bout;
    logic         busy;
    logic         done;
    logic         ovf;

    int pass_cnt;
    int total_cnt;

    serial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .a     (a),
        .b     (b),
        .diff  (diff),
        .bout  (bout),
        .busy  (busy),
`ifdef SERIAL_SUB_OVF_EN
        .done  (done),
        .ovf   (ovf)
`else
        .done  (done)
`endif
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation. load stays high for load_extra SHIFT edges after the start edge and
    // for done_hold cycles in DONE; toggle scrambles a/b after the start edge.
    task automatic do_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                         input int load_extra, input int done_hold, input bit toggle,
                         input string tag);
        int signed_a, signed_b, signed_d;
        logic [N-1:0] exp_diff;
        logic exp_bout, exp_ovf;
        int ua, ub;
        ua = int'(av);
        ub = int'(bv);
        exp_diff = N'((ua - ub) & int'(MASK));
        exp_bout = (ua < ub);
        signed_a = av[N-1] ? ua - (1 << N) : ua;
        signed_b = bv[N-1] ? ub - (1 << N) : ub;
        signed_d = signed_a - signed_b;
        exp_ovf  = OVF_EN && ((signed_d > (1 << (N-1)) - 1) || (signed_d < -(1 << (N-1))));

        a = av; b = bv; load = 1'b1;
        step();
        for (int i = 1; i <= N; i++) begin
            total_cnt++;
            if ({busy, done} !== 2'b10) $display("FAIL %s busy/done shift%0d: got %b want 10", tag, i, {busy, done});
            else pass_cnt++;
            load = (i <= load_extra);
            if (toggle) begin
                a = N'($urandom);
                b = N'($urandom);
            end
            step();
        end
        total_cnt++;
        if ({busy, done} !== 2'b01) $display("FAIL %s done rise: got busy/done=%b want 01", tag, {busy, done});
        else pass_cnt++;
        total_cnt++;
        if ({diff, bout, ovf} !== {exp_diff, exp_bout, exp_ovf})
            $display("FAIL %s result: got diff=%b bout=%b ovf=%b want diff=%b bout=%b ovf=%b",
                     tag, diff, bout, ovf, exp_diff, exp_bout, exp_ovf);
        else pass_cnt++;
        for (int k = 0; k < done_hold; k++) begin
            load = 1'b1;
            step();
            total_cnt++;
            if ({busy, done, diff, bout, ovf} !== {2'b01, exp_diff, exp_bout, exp_ovf})
                $display("FAIL %s done hold%0d: got busy/done=%b diff=%b bout=%b want 01 %b %b",
                         tag, k, {busy, done}, diff, bout, exp_diff, exp_bout);
            else pass_cnt++;
        end
        load = 1'b0;
        step();
        total_cnt++;
        if ({busy, done, bout, ovf} !== 4'b0000)
            $display("FAIL %s back to idle: got busy/done/bout/ovf=%b want 0000", tag, {busy, done, bout, ovf});
        else pass_cnt++;
        $display("op %s a=%b b=%b diff=%b bout=%b ovf=%b", tag, av, bv, exp_diff, exp_bout, exp_ovf);
    endtask

    task automatic test_reset();
        reset = 1'b0; load = 1'b0; a = '0; b = '0;
        step();
        step();
        total_cnt++;
        if ({diff, bout, busy, done, ovf} !== '0)
            $display("FAIL reset state: got diff=%b bout=%b busy=%b done=%b ovf=%b want all 0", diff, bout, busy, done, ovf);
        else pass_cnt++;
        #2 reset = 1'b1;
        step();
        total_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL idle after reset: got busy/done=%b want 00", {busy, done});
        else pass_cnt++;
    endtask

    task automatic test_vectors();
        do_op(4'b1111, 4'b0111, 1, 0, 1'b0, "v15m7");
        do_op(4'b0111, 4'b1111, 0, 0, 1'b0, "v7m15");
        do_op(4'b1110, 4'b0111, 0, 0, 1'b0, "v14m7");
        do_op(4'b0010, 4'b1001, 0, 0, 1'b0, "v2m9");
        do_op(4'b0000, 4'b0000, 0, 0, 1'b0, "zero");
        do_op(4'b0000, 4'b0001, 0, 0, 1'b0, "wrap");
    endtask

    task automatic test_load_hold();
        do_op(4'b1010, 4'b0011, N, 5, 1'b0, "hold");
        step();
        total_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL hold no restart: got busy/done=%b want 00", {busy, done});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_shift();
        a = 4'b1100; b = 4'b0001; load = 1'b1;
        step();
        load = 1'b0;
        step();
        #1 reset = 1'b0;
        #1;
        total_cnt++;
        if ({diff, bout, busy, done, ovf} !== '0)
            $display("FAIL async abort: got diff=%b bout=%b busy=%b done=%b ovf=%b want all 0", diff, bout, busy, done, ovf);
        else pass_cnt++;
        #2 reset = 1'b1;
        step();
        total_cnt++;
        if ({busy, done, diff} !== '0) $display("FAIL idle after abort: got busy/done=%b diff=%b want 0", {busy, done}, diff);
        else pass_cnt++;
        do_op(4'b0101, 4'b0011, 0, 0, 1'b0, "post_rst");
    endtask

    task automatic test_toggle();
        for (int t = 0; t < 4; t++)
            do_op(N'($urandom), N'($urandom), 0, 0, 1'b1, "toggle");
    endtask

    task automatic test_random();
        for (int r = 0; r < 20; r++)
            do_op(N'($urandom), N'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), "rand");
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_vectors();
        test_load_hold();
        test_reset_mid_shift();
        test_toggle();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor, the inverse-operation companion to serial_adder, with the same load/shift protocol.
- Captures parallel operands a and b on load.
- Computes a - b LSB-first, one bit per clock, through a single 1-bit full-subtractor cell and a borrow flip-flop.
- Presents the parallel difference and the final borrow with a done flag.
- Used in the same datapath/testbench environment as serial_adder.

Parameters:
N, 4, operand and result width in bits (N >= 1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
load  input  1  level start request; sampled high in IDLE starts an operation
a  input  N  minuend, sampled on the start edge
b  input  N  subtrahend, sampled on the start edge
diff  output  N  a - b mod 2^N; valid while done=1
bout  output  1  final borrow (1 when unsigned a < b); valid while done=1
busy  output  1  high while in SHIFT
done  output  1  high while in DONE

Behaviour:
- Reset (reset=0, async): state=IDLE; operand shift regs=0; result reg=0; borrow=0; count=0; diff=0, bout=0, busy=0, done=0. Reset release takes effect at the next clk edge.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load=1 at an edge: ra<=a, rb<=b, borrow<=0, count<=0, result<=0; go to SHIFT.
  - load=0: stay in IDLE.
- SHIFT, each edge:
  - d = ra[0]^rb[0]^borrow.
  - borrow <= (~ra[0]&rb[0]) | (~(ra[0]^rb[0])&borrow).
  - result <= {d, result[N-1:1]}; ra, rb shift right, zero-filled; count<=count+1.
  - When count==N-1, go to DONE on that edge.
  - load is ignored in SHIFT.
- Latency: done rises exactly N clock edges after the start edge; busy is high for exactly N cycles.
- DONE:
  - diff=result, bout=borrow, done=1; all held stable.
  - Go to IDLE on the first edge with load=0.
  - load still high from the start (e.g. a 2-cycle load pulse) never retriggers; a new operation needs load low, then high.
- diff is driven from the result register in every state, so it shows partial bits during SHIFT. Consumers qualify it with done.
- bout is 0 outside DONE.
- Wrap-around: the result is modulo 2^N; bout is the only indication of underflow.
- Reset mid-SHIFT or mid-DONE: immediate abort to reset values; no partial result is retained.
- All registers are updated only on clk or on reset assertion; no combinational path from a or b to the outputs.

Optional Feature:
SERIAL_SUB_OVF_EN
- Defined:
  - Adds output ovf (1 bit), the two's-complement overflow: (a[N-1]!=b[N-1]) && (diff[N-1]!=a[N-1]).
  - Computed from the captured operand MSBs, registered, valid with done.
  - 0 in reset, IDLE and SHIFT.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package serial_arith_pkg:
  - state enum type (IDLE, SHIFT, DONE);
  - count width constant $clog2(N+1) as a function;
  - also reused by serial_adder.
- One sub-module, serial_full_subtractor: combinational 1-bit cell (x, y, bin -> d, bout), instantiated once.
- FSM, shift registers and counter live in the top module.

Test Plan:
- Reset, then a=1111, b=0111, load high for 2 cycles:
  - busy high for 4 cycles, then done=1 with diff=1000, bout=0;
  - ovf=0 if enabled.
- a=0111, b=1111: diff=1000, bout=1; ovf=1 if enabled (7 - (-1) overflows).
- a=1110, b=0111: diff=0111, bout=0. a=0010, b=1001: diff=1001, bout=1.
- Hold load high through DONE for 5 cycles: no restart; done stays 1 until load drops, then IDLE next edge.
- Assert reset=0 mid-edge during SHIFT cycle 2:
  - outputs go to 0 immediately, state IDLE;
  - a subsequent a=0101, b=0011 gives diff=0010, bout=0.
- Toggle a and b every cycle during SHIFT: the result still reflects the values captured on the start edge.
